// File: rtl/fifo_packet_reader.sv
// Drains the packet FIFO into a valid/ready stream through a 2-entry skid buffer, with framing checks.
// Optional framing checks (drops, forced EOP, sticky o_err) are enabled by FIFO_PACKET_READER_ERR_CHECK_EN.
module fifo_packet_reader #(
   parameter int unsigned DATA_LINE_WIDTH    = 64,
   parameter int unsigned CONTROL_LINE_WIDTH = 6,
   parameter int unsigned MAX_PKT_BEATS      = 16
) (
   input  logic                                        clk,
   input  logic                                        rst_n,
   input  logic                                        i_empty_flag,
   output logic                                        o_read_packet_en,
   input  logic [DATA_LINE_WIDTH+CONTROL_LINE_WIDTH-1:0] i_read_packet,
   output logic [DATA_LINE_WIDTH-1:0]                  o_data,
   output logic [CONTROL_LINE_WIDTH-3:0]               o_ctrl,
   output logic                                        o_sop,
   output logic                                        o_eop,
   output logic                                        o_valid,
   input  logic                                        i_ready,
   output logic [15:0]                                 o_pkt_count,
   output logic                                        o_err
);
   localparam int unsigned LW = DATA_LINE_WIDTH + CONTROL_LINE_WIDTH;

   logic                          in_sop, in_eop;
   logic [CONTROL_LINE_WIDTH-3:0] in_side;
   logic [DATA_LINE_WIDTH-1:0]    in_data;
   logic [LW-1:0]                 ent0_q, ent0_d, ent1_q, ent1_d, wr_line;
   logic [1:0]                    occ_q, occ_d;
   logic                          inflight_q;
   logic [15:0]                   cnt_q;
   logic                          wr_en, wr_eop, push, deq;
   logic [2:0]                    credit_use;

   assign in_sop  = i_read_packet[LW-1];
   assign in_eop  = i_read_packet[LW-2];
   assign in_side = i_read_packet[LW-3:DATA_LINE_WIDTH];
   assign in_data = i_read_packet[DATA_LINE_WIDTH-1:0];

   // Buffer entries keep the line layout, with the EOP bit possibly forced.
   assign wr_line = {in_sop, wr_eop, in_side, in_data};
   assign push    = inflight_q && wr_en;
   assign o_valid = (occ_q != 2'd0);
   assign {o_sop, o_eop, o_ctrl, o_data} = ent0_q;
   assign deq     = o_valid && i_ready;
   assign o_pkt_count = cnt_q;

   // Slots committed after this edge: buffered + arriving - leaving must stay below 2 to pop.
   assign credit_use = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, deq};
   assign o_read_packet_en = rst_n && !i_empty_flag && (credit_use < 3'd2);

   always_comb begin
      ent0_d = ent0_q;
      ent1_d = ent1_q;
      occ_d  = occ_q;
      if (deq) begin
         ent0_d = ent1_q;
         occ_d  = occ_d - 2'd1;
      end
      if (push) begin
         if (occ_d == 2'd0) ent0_d = wr_line;
         else               ent1_d = wr_line;
         occ_d = occ_d + 2'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ent0_q     <= '0;
         ent1_q     <= '0;
         occ_q      <= 2'd0;
         inflight_q <= 1'b0;
         cnt_q      <= 16'd0;
      end else begin
         ent0_q     <= ent0_d;
         ent1_q     <= ent1_d;
         occ_q      <= occ_d;
         inflight_q <= o_read_packet_en;
         if (deq && o_eop) cnt_q <= cnt_q + 16'd1;
      end
   end

`ifdef FIFO_PACKET_READER_ERR_CHECK_EN
   typedef enum logic {IDLE, IN_PKT} state_t;
   state_t     state_q, state_d;
   logic [7:0] beat_q, beat_d;
   logic       err_q, err_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         beat_q  <= 8'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      err_d   = err_q;
      wr_en   = 1'b0;
      wr_eop  = in_eop;
      if (inflight_q) begin
         case (state_q)
            IDLE: begin
               if (!in_sop) begin
                  err_d = 1'b1;
               end else begin
                  wr_en = 1'b1;
                  if (!in_eop) begin
                     state_d = IN_PKT;
                     beat_d  = 8'd1;
                  end
               end
            end
            default: begin
               wr_en = 1'b1;
               if (in_sop) begin
                  // Restart framing on the new SOP; the old packet stays unterminated.
                  err_d  = 1'b1;
                  beat_d = 8'd1;
                  if (in_eop) state_d = IDLE;
               end else if (in_eop) begin
                  state_d = IDLE;
                  beat_d  = 8'd0;
               end else if (beat_q + 8'd1 == 8'(MAX_PKT_BEATS)) begin
                  wr_eop  = 1'b1;
                  err_d   = 1'b1;
                  state_d = IDLE;
                  beat_d  = 8'd0;
               end else begin
                  beat_d = beat_q + 8'd1;
               end
            end
         endcase
      end
   end

   assign o_err = err_q;
`else
   logic unused_max_beats;
   assign unused_max_beats = ^MAX_PKT_BEATS;
   assign wr_en  = 1'b1;
   assign wr_eop = in_eop;
   assign o_err  = 1'b0;
`endif
endmodule

// File: tb/tb_fifo_packet_reader.sv
// Bench for fifo_packet_reader: FIFO emulation, packet-level reference model, table rows and random traffic.
module tb_fifo_packet_reader;
   localparam int LW   = 70;
   localparam int MAXB = 16;
`ifdef FIFO_PACKET_READER_ERR_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          i_empty_flag = 1'b1;
   logic          i_ready = 1'b0;
   logic [LW-1:0] i_read_packet = '0;
   logic          o_read_packet_en, o_sop, o_eop, o_valid, o_err;
   logic [63:0]   o_data;
   logic [3:0]    o_ctrl;
   logic [15:0]   o_pkt_count;

   always #5 clk = ~clk;

   fifo_packet_reader #(.DATA_LINE_WIDTH(64), .CONTROL_LINE_WIDTH(6), .MAX_PKT_BEATS(MAXB)) dut (
      .clk(clk), .rst_n(rst_n), .i_empty_flag(i_empty_flag), .o_read_packet_en(o_read_packet_en),
      .i_read_packet(i_read_packet), .o_data(o_data), .o_ctrl(o_ctrl), .o_sop(o_sop), .o_eop(o_eop),
      .o_valid(o_valid), .i_ready(i_ready), .o_pkt_count(o_pkt_count), .o_err(o_err));

   typedef struct {
      int kind;       // 0 normal, 1 stray line first, 2 no EOP, 3 SOP again at beat 2
      int nbeats;
      int npkts;
      int rmode;      // 0 ready=1, 1 toggle, 2 random, 3 ready=0
      int exp_beats;
      int exp_cnt;
      bit exp_err;
   } vec_t;

   int errors = 0, checks = 0, cyc = 0, pops = 0, acc_n = 0, maxout = 0;
   int rmode = 0, feed_pct = 100, m_len = 0;
   bit m_err = 1'b0, hold_pend = 1'b0;
   logic [15:0]   m_cnt = '0;
   logic [LW-1:0] held = '0;
   logic [LW-1:0] fifo_q[$], pending[$], exp_q[$];
   int pop_cyc[$], acc_cyc[$];
   vec_t tbl[8];

   task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic emit(input logic [LW-1:0] l);
      exp_q.push_back(l);
      if (l[LW-2]) m_cnt++;
   endtask

   // Reference: packet-level framing rules applied to each line in FIFO order.
   task automatic add_line(input bit sop, input bit eop);
      logic [LW-1:0] l;
      l = {sop, eop, 4'($urandom), $urandom, $urandom};
      pending.push_back(l);
      if (!CHK) emit(l);
      else if (m_len == 0) begin
         if (!sop) m_err = 1'b1;
         else begin emit(l); m_len = eop ? 0 : 1; end
      end else if (sop) begin
         m_err = 1'b1; emit(l); m_len = eop ? 0 : 1;
      end else if (eop) begin
         emit(l); m_len = 0;
      end else if (m_len + 1 == MAXB) begin
         l[LW-2] = 1'b1; emit(l); m_err = 1'b1; m_len = 0;
      end else begin
         emit(l); m_len++;
      end
   endtask

   task automatic build(input int kind, input int nb);
      if (kind == 1) add_line(1'b0, 1'b0);
      for (int i = 0; i < nb; i++) begin
         case (kind)
            2:       add_line(i == 0, 1'b0);
            3:       add_line(i == 0 || i == 2, i == nb - 1);
            default: add_line(i == 0, i == nb - 1);
         endcase
      end
   endtask

   // One cycle: observe at negedge, emulate the FIFO, drive new inputs just after posedge.
   task automatic tick();
      logic [LW-1:0] cur, nxt;
      @(negedge clk);
      cyc++;
      cur = {o_sop, o_eop, o_ctrl, o_data};
      if (hold_pend) chk("hold_stable", 72'({o_valid, cur}), 72'({1'b1, held}));
      if (i_empty_flag) chk("no_pop_when_empty", 72'(o_read_packet_en), 72'(0));
      if (o_valid && i_ready) begin
         acc_n++;
         acc_cyc.push_back(cyc);
         if (exp_q.size() == 0) chk("unexpected_beat", 72'({1'b1, cur}), 72'(0));
         else chk("beat", 72'(cur), 72'(exp_q.pop_front()));
      end
      hold_pend = o_valid && !i_ready;
      held = cur;
      nxt = LW'({$urandom, $urandom, $urandom});
      if (o_read_packet_en) begin
         pops++;
         pop_cyc.push_back(cyc);
         if (fifo_q.size() > 0) nxt = fifo_q.pop_front();
      end
      if (pops - acc_n > maxout) maxout = pops - acc_n;
      @(posedge clk);
      #1;
      i_read_packet = nxt;
      if (pending.size() > 0 && $urandom_range(99) < feed_pct) fifo_q.push_back(pending.pop_front());
      i_empty_flag = (fifo_q.size() == 0);
      case (rmode)
         0:       i_ready = 1'b1;
         1:       i_ready = !i_ready;
         2:       i_ready = ($urandom_range(99) < 70);
         default: i_ready = 1'b0;
      endcase
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      fifo_q.delete(); pending.delete(); exp_q.delete(); pop_cyc.delete(); acc_cyc.delete();
      pops = 0; acc_n = 0; maxout = 0; hold_pend = 1'b0;
      m_len = 0; m_err = 1'b0; m_cnt = '0; feed_pct = 100;
      i_empty_flag = 1'b1;
      repeat (2) tick();
      chk("rst_ctl", 72'({o_valid, o_sop, o_eop, o_ctrl, o_read_packet_en, o_err, o_pkt_count}), 72'(0));
      chk("rst_data", 72'(o_data), 72'(0));
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while ((pending.size() + fifo_q.size() + exp_q.size()) > 0 && n < budget) begin
         tick();
         n++;
      end
      chk("drain_in_budget", 72'(n < budget), 72'(1));
      repeat (4) tick();
   endtask

   initial begin
      // Reset release with a 3-beat packet already waiting in the FIFO.
      rmode = 0;
      do_reset();
      build(0, 3);
      tick();
      chk("s1_no_pop_in_reset", 72'(o_read_packet_en), 72'(0));
      rst_n = 1'b1;
      drain(200);
      chk("s1_beats", 72'(acc_cyc.size()), 72'(3));
      if (acc_cyc.size() == 3 && pop_cyc.size() > 0) begin
         chk("s1_first_latency", 72'(acc_cyc[0]), 72'(pop_cyc[0] + 2));
         chk("s1_back_to_back", 72'(acc_cyc[2]), 72'(acc_cyc[0] + 2));
      end
      chk("s1_cnt", 72'(o_pkt_count), 72'(1));
      chk("s1_err", 72'(o_err), 72'(0));

      tbl[0] = '{0, 1, 1, 0, 1, 1, 1'b0};
      tbl[1] = '{0, 3, 1, 2, 3, 1, 1'b0};
      tbl[2] = '{0, 16, 1, 1, 16, 1, 1'b0};
      tbl[3] = '{0, 1, 32, 1, 32, 32, 1'b0};
      tbl[4] = '{1, 2, 1, 0, CHK ? 2 : 3, 1, CHK};
      tbl[5] = '{2, 20, 1, 0, CHK ? 16 : 20, CHK ? 1 : 0, CHK};
      tbl[6] = '{2, 16, 1, 2, 16, CHK ? 1 : 0, CHK};
      tbl[7] = '{3, 5, 1, 1, 5, 1, CHK};
      for (int r = 0; r < 8; r++) begin
         rmode = tbl[r].rmode;
         do_reset();
         for (int p = 0; p < tbl[r].npkts; p++) build(tbl[r].kind, tbl[r].nbeats);
         rst_n = 1'b1;
         drain(2000);
         chk($sformatf("row%0d_beats", r), 72'(acc_n), 72'(tbl[r].exp_beats));
         chk($sformatf("row%0d_cnt", r), 72'(o_pkt_count), 72'(tbl[r].exp_cnt));
         chk($sformatf("row%0d_err", r), 72'(o_err), 72'(tbl[r].exp_err));
         if (tbl[r].kind == 0) chk($sformatf("row%0d_outstanding", r), 72'(maxout <= 2), 72'(1));
      end

      // Asynchronous reset with one line buffered and one pop in flight.
      rmode = 3;
      do_reset();
      build(0, 6);
      rst_n = 1'b1;
      repeat (3) tick();
      #1;
      chk("s6_valid_before_reset", 72'(o_valid), 72'(1));
      rst_n = 1'b0;
      #1;
      chk("s6_async_ctl", 72'({o_valid, o_sop, o_eop, o_ctrl, o_read_packet_en, o_err, o_pkt_count}), 72'(0));
      chk("s6_async_data", 72'(o_data), 72'(0));
      do_reset();
      rmode = 0;
      build(0, 2);
      rst_n = 1'b1;
      drain(200);
      chk("s6_beats_after_reset", 72'(acc_n), 72'(2));
      chk("s6_cnt", 72'(o_pkt_count), 72'(1));

      // Random traffic against the reference model.
      rmode = 2;
      do_reset();
      feed_pct = 60;
      for (int p = 0; p < 150; p++) begin
         int k;
         k = $urandom_range(9);
         if (k <= 6)      build(0, $urandom_range(12, 1));
         else if (k == 7) build(1, $urandom_range(4, 1));
         else if (k == 8) build(2, $urandom_range(20, 17));
         else             build(3, $urandom_range(8, 4));
      end
      rst_n = 1'b1;
      drain(20000);
      chk("rand_cnt", 72'(o_pkt_count), 72'(m_cnt));
      chk("rand_err", 72'(o_err), 72'(m_err));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
